// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush generation, forwarding selects
// and the multiply/divide busy counter for the five-stage datapath.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [1:0] tuse_rsD,
    input  logic [1:0] tuse_rtD,
    input  logic [4:0] ra1E,
    input  logic [4:0] ra2E,
    input  logic [4:0] ra2M,
    input  logic [4:0] waE,
    input  logic [4:0] waM,
    input  logic [4:0] waW,
    input  logic [2:0] resE,
    input  logic [2:0] resM,
    input  logic [2:0] resW,
    input  logic       md_useD,
    input  logic       md_startE,
    input  logic       md_divE,
    input  logic       exc_req,
    output logic       stallF,
    output logic       stallD,
    output logic       clrE,
    output logic       DEMWclr,
    output logic       md_busy,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned RES_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [RES_W-1:0] RES_ALU = 3'd1;
    localparam logic [RES_W-1:0] RES_DM  = 3'd2;
    localparam logic [RES_W-1:0] RES_PC  = 3'd3;
    localparam logic [RES_W-1:0] RES_MD  = 3'd4;

    logic [CNT_W-1:0] md_cnt;
    logic             data_stall;
    logic             md_stall;

    function automatic logic produces(input logic [RES_W-1:0] res);
        return (res == RES_ALU) || (res == RES_DM) || (res == RES_PC) || (res == RES_MD);
    endfunction

    function automatic logic [1:0] tnew_e(input logic [RES_W-1:0] res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            RES_MD:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [RES_W-1:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // Source register matches a live producer tag (register $0 never matches)
    function automatic logic hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] wa,
                                 input logic [RES_W-1:0] res);
        return (src != '0) && (src == wa) && produces(res);
    endfunction

    function automatic logic src_stall(input logic [REG_W-1:0] src, input logic [1:0] tuse,
                                       input logic [REG_W-1:0] wa_e, input logic [RES_W-1:0] res_e,
                                       input logic [REG_W-1:0] wa_m, input logic [RES_W-1:0] res_m);
        return (hit(src, wa_e, res_e) && (tnew_e(res_e) > tuse)) ||
               (hit(src, wa_m, res_m) && (tnew_m(res_m) > tuse));
    endfunction

    function automatic logic [1:0] sel_d(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wa_e, input logic [RES_W-1:0] res_e,
                                         input logic [REG_W-1:0] wa_m, input logic [RES_W-1:0] res_m);
        if (hit(src, wa_e, res_e) && (res_e == RES_PC))           return 2'd1;
        else if (hit(src, wa_m, res_m) && (tnew_m(res_m) == 2'd0)) return 2'd2;
        else                                                       return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wa_m, input logic [RES_W-1:0] res_m,
                                         input logic [REG_W-1:0] wa_w, input logic [RES_W-1:0] res_w);
        if (hit(src, wa_m, res_m) && (tnew_m(res_m) == 2'd0)) return 2'd1;
        else if (hit(src, wa_w, res_w))                       return 2'd2;
        else                                                  return 2'd0;
    endfunction

    // MD busy counter; a start reloads even while busy and survives flushes
    always_ff @(posedge clk) begin
        if (!rst) begin
            md_cnt <= '0;
        end else if (md_startE) begin
            md_cnt <= md_divE ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

    // Flush wins over stall; reset silences every control output
    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        clrE    = 1'b0;
        DEMWclr = 1'b0;
        fwd_rsD = 2'd0;
        fwd_rtD = 2'd0;
        fwd_rsE = 2'd0;
        fwd_rtE = 2'd0;
        fwd_rtM = 1'b0;

        data_stall = src_stall(ra1D, tuse_rsD, waE, resE, waM, resM) ||
                     src_stall(ra2D, tuse_rtD, waE, resE, waM, resM);
        md_stall   = md_useD && (md_startE || md_busy);

        if (rst) begin
            DEMWclr = exc_req;
            if (!exc_req && (data_stall || md_stall)) begin
                stallF = 1'b1;
                stallD = 1'b1;
                clrE   = 1'b1;
            end
            fwd_rsD = sel_d(ra1D, waE, resE, waM, resM);
            fwd_rtD = sel_d(ra2D, waE, resE, waM, resM);
            fwd_rsE = sel_e(ra1E, waM, resM, waW, resW);
            fwd_rtE = sel_e(ra2E, waM, resM, waW, resW);
            fwd_rtM = hit(ra2M, waW, resW);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios with literal
// expectations, plus a per-cycle comparison against a rule-level model.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ra1D, ra2D, ra1E, ra2E, ra2M, waE, waM, waW;
    logic [1:0] tuse_rsD, tuse_rtD;
    logic [2:0] resE, resM, resW;
    logic       md_useD, md_startE, md_divE, exc_req;
    logic       stallF, stallD, clrE, DEMWclr, md_busy, fwd_rtM;
    logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Tnew tables indexed by result class; NW and 5-7 never produce
    int tn_e [8] = '{0, 1, 2, 0, 1, 0, 0, 0};
    int tn_m [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    bit prod [8] = '{0, 1, 1, 1, 1, 0, 0, 0};

    // MD model: last cycle index in which the unit reports busy
    int cyc = 0;
    int busy_last = -1;

    hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .tuse_rsD(tuse_rsD), .tuse_rtD(tuse_rtD),
        .ra1E(ra1E), .ra2E(ra2E), .ra2M(ra2M),
        .waE(waE), .waM(waM), .waW(waW),
        .resE(resE), .resM(resM), .resW(resW),
        .md_useD(md_useD), .md_startE(md_startE), .md_divE(md_divE), .exc_req(exc_req),
        .stallF(stallF), .stallD(stallD), .clrE(clrE), .DEMWclr(DEMWclr), .md_busy(md_busy),
        .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD), .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE),
        .fwd_rtM(fwd_rtM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst)           busy_last <= cyc;
        else if (md_startE) busy_last <= cyc + (md_divE ? DIV_N : MULT_N);
    end

    function automatic bit m_src_stall(input logic [4:0] s, input logic [1:0] tu);
        return (s != 0) && (((s == waE) && prod[resE] && (tn_e[resE] > int'(tu))) ||
                            ((s == waM) && prod[resM] && (tn_m[resM] > int'(tu))));
    endfunction

    function automatic int m_fwd_d(input logic [4:0] s);
        if ((s != 0) && (s == waE) && prod[resE] && (tn_e[resE] == 0)) return 1;
        if ((s != 0) && (s == waM) && prod[resM] && (tn_m[resM] == 0)) return 2;
        return 0;
    endfunction

    function automatic int m_fwd_e(input logic [4:0] s);
        if ((s != 0) && (s == waM) && prod[resM] && (tn_m[resM] == 0)) return 1;
        if ((s != 0) && (s == waW) && prod[resW]) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin : cmp
        bit m_busy, m_stall, m_live;
        if (checking) begin
            m_live  = (rst === 1'b1);
            m_busy  = (cyc <= busy_last);
            m_stall = m_live && !exc_req &&
                      (m_src_stall(ra1D, tuse_rsD) || m_src_stall(ra2D, tuse_rtD) ||
                       (md_useD && (md_startE || m_busy)));
            chk("m_md_busy", int'(md_busy), int'(m_busy));
            chk("m_stallF",  int'(stallF),  int'(m_stall));
            chk("m_stallD",  int'(stallD),  int'(m_stall));
            chk("m_clrE",    int'(clrE),    int'(m_stall));
            chk("m_DEMWclr", int'(DEMWclr), int'(m_live && exc_req));
            chk("m_fwd_rsD", int'(fwd_rsD), m_live ? m_fwd_d(ra1D) : 0);
            chk("m_fwd_rtD", int'(fwd_rtD), m_live ? m_fwd_d(ra2D) : 0);
            chk("m_fwd_rsE", int'(fwd_rsE), m_live ? m_fwd_e(ra1E) : 0);
            chk("m_fwd_rtE", int'(fwd_rtE), m_live ? m_fwd_e(ra2E) : 0);
            chk("m_fwd_rtM", int'(fwd_rtM),
                int'(m_live && (ra2M != 0) && (ra2M == waW) && prod[resW]));
        end
    end

    task automatic idle_inputs();
        ra1D = 0; ra2D = 0; ra1E = 0; ra2E = 0; ra2M = 0;
        waE = 0; waM = 0; waW = 0;
        resE = 0; resM = 0; resW = 0;
        tuse_rsD = 2'd3; tuse_rtD = 2'd3;
        md_useD = 0; md_startE = 0; md_divE = 0; exc_req = 0;
    endtask

    // Settle to mid-cycle (checks happen here), then move to just after the next edge
    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [1:0] tu);
        resE = 3'd2; waE = 5'd8; ra1D = 5'd8; tuse_rsD = tu;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        checking = 1'b1;

        // Reset state
        to_mid();
        chk("rst_busy", int'(md_busy), 0);
        chk("rst_stall", int'(stallF), 0);
        next_cycle();

        // Load-use: one stall with load in E, none once it reaches M
        load_use(2'd1);
        to_mid();
        chk("lu_stallF", int'(stallF), 1);
        chk("lu_stallD", int'(stallD), 1);
        chk("lu_clrE", int'(clrE), 1);
        next_cycle();
        idle_inputs();
        resM = 3'd2; waM = 5'd8; ra1D = 5'd8; tuse_rsD = 2'd1;
        to_mid();
        chk("lu_m_nostall", int'(stallF), 0);
        chk("lu_m_fwd", int'(fwd_rsD), 0);
        next_cycle();
        idle_inputs();
        load_use(2'd2);
        to_mid();
        chk("lu_tuse2", int'(stallF), 0);
        next_cycle();

        // Register $0 never stalls or forwards
        idle_inputs();
        waE = 0; resE = 3'd1; ra1D = 0; tuse_rsD = 2'd0;
        to_mid();
        chk("r0_stall", int'(stallF), 0);
        chk("r0_fwd", int'(fwd_rsD), 0);
        next_cycle();

        // Forward priority in E, PC forwarding from E to D, store data from W
        idle_inputs();
        ra1E = 5'd5; waM = 5'd5; resM = 3'd1; waW = 5'd5; resW = 3'd2;
        resE = 3'd3; waE = 5'd9; ra2D = 5'd9; tuse_rtD = 2'd0;
        ra2M = 5'd5;
        to_mid();
        chk("fp_m", int'(fwd_rsE), 1);
        chk("fd_pc", int'(fwd_rtD), 1);
        chk("fd_pc_nostall", int'(stallF), 0);
        chk("fm_w", int'(fwd_rtM), 1);
        next_cycle();
        resM = 3'd0;
        to_mid();
        chk("fp_w", int'(fwd_rsE), 2);
        next_cycle();

        // Flush beats a load-use stall
        idle_inputs();
        load_use(2'd1);
        exc_req = 1'b1;
        to_mid();
        chk("fl_clr", int'(DEMWclr), 1);
        chk("fl_stallF", int'(stallF), 0);
        chk("fl_clrE", int'(clrE), 0);
        next_cycle();

        // Divide with MD-using D instruction: stall cycles 0..10, release 11
        idle_inputs();
        md_useD = 1; md_startE = 1; md_divE = 1;
        to_mid();
        chk("dv_c0_stall", int'(stallF), 1);
        next_cycle();
        md_startE = 0; md_divE = 0;
        for (int k = 1; k <= DIV_N; k++) begin
            to_mid();
            chk($sformatf("dv_c%0d_stall", k), int'(stallF), 1);
            chk($sformatf("dv_c%0d_busy", k), int'(md_busy), 1);
            next_cycle();
        end
        to_mid();
        chk("dv_rel_stall", int'(stallF), 0);
        chk("dv_rel_busy", int'(md_busy), 0);
        next_cycle();

        // Restart while busy: divide, then mult two cycles later reloads
        idle_inputs();
        md_startE = 1; md_divE = 1;
        next_cycle();
        md_startE = 0; md_divE = 0;
        next_cycle();
        md_startE = 1;
        next_cycle();
        md_startE = 0;
        for (int k = 1; k <= MULT_N + 1; k++) next_cycle();
        to_mid();
        chk("rl_done", int'(md_busy), 0);
        next_cycle();

        // Reset mid-multiply with hazards and exception presented
        idle_inputs();
        md_startE = 1;
        next_cycle();
        md_startE = 0;
        next_cycle();
        rst = 1'b0;
        load_use(2'd1);
        exc_req = 1'b1;
        ra1E = 5'd5; waM = 5'd5; resM = 3'd1;
        to_mid();
        chk("rs_stallF", int'(stallF), 0);
        chk("rs_demw", int'(DEMWclr), 0);
        chk("rs_fwd", int'(fwd_rsE), 0);
        next_cycle();
        to_mid();
        chk("rs_busy", int'(md_busy), 0);
        chk("rs_clrE", int'(clrE), 0);
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();

        // Pseudo-random tag traffic on a narrow register range to force collisions
        for (int k = 0; k < 60; k++) begin
            ra1D = 5'($urandom_range(0, 3)); ra2D = 5'($urandom_range(0, 3));
            ra1E = 5'($urandom_range(0, 3)); ra2E = 5'($urandom_range(0, 3));
            ra2M = 5'($urandom_range(0, 3));
            waE = 5'($urandom_range(0, 3)); waM = 5'($urandom_range(0, 3));
            waW = 5'($urandom_range(0, 3));
            resE = 3'($urandom_range(0, 7)); resM = 3'($urandom_range(0, 7));
            resW = 3'($urandom_range(0, 7));
            tuse_rsD = 2'($urandom_range(0, 3)); tuse_rtD = 2'($urandom_range(0, 3));
            md_useD = 1'($urandom_range(0, 1));
            md_startE = ($urandom_range(0, 7) == 0);
            md_divE = 1'($urandom_range(0, 1));
            exc_req = ($urandom_range(0, 7) == 0);
            next_cycle();
        end
        idle_inputs();
        to_mid();
        checking = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline controller for the five-stage MIPS datapath. It compares the D-stage source registers against the destination/result tags (`wa`, `res`) carried by the E, M and W pipeline registers and produces stall, bubble and forwarding-select signals. It also owns the multiply/divide busy counter and the exception flush (`DEMWclr`) that clears the D/E/M/W tag registers.

## Interface
- `MULT_CYC`, 5, busy cycles for mult/multu
- `DIV_CYC`, 10, busy cycles for div/divu
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low
- `ra1D`, `ra2D` in 5: rs/rt of the instruction in D
- `tuse_rsD`, `tuse_rtD` in 2: cycles until D needs rs/rt (0..2; 3 = never used)
- `ra1E`, `ra2E` in 5: rs/rt in E
- `ra2M` in 5: rt in M (store data)
- `waE`, `waM`, `waW` in 5: destination register per stage
- `resE`, `resM`, `resW` in 3: result class per stage (0 NW, 1 ALU, 2 DM, 3 PC, 4 MD; 5-7 treated as NW)
- `md_useD` in 1: D instruction touches HI/LO or the MD unit
- `md_startE` in 1: E instruction starts the MD unit
- `md_divE` in 1: the start is a divide
- `exc_req` in 1: exception/interrupt accepted this cycle
- `stallF`, `stallD` out 1: hold PC and the F/D register
- `clrE` out 1: insert a bubble into the D/E register
- `DEMWclr` out 1: flush the D/E/M/W registers
- `md_busy` out 1: MD unit busy
- `fwd_rsD`, `fwd_rtD` out 2: 0 regfile, 1 from E, 2 from M
- `fwd_rsE`, `fwd_rtE` out 2: 0 pipe value, 1 from M, 2 from W
- `fwd_rtM` out 1: 0 pipe value, 1 from W

## Operation
- Tnew per stage:
  - E: ALU=1, DM=2, PC=0, MD=1
  - M: ALU=0, DM=1, PC=0, MD=0
  - W: all 0
  - NW never produces.
- Data stall: for each source `s` in {rs, rt} and each stage X in {E, M}, stall when all of the following hold:
  - `s != 0`
  - `s == waX`
  - `resX != NW`
  - `TnewX > tuse_s`
- `tuse = 3` never stalls.
- MD stall: `md_useD && (md_startE || md_busy)`.
- `stall` = data stall OR MD stall. When stall is high: `stallF = stallD = clrE = 1`.
- Forwarding applies only when the register is nonzero, tags match, and the producer has Tnew = 0 at that stage. The nearest stage wins.
  - D selects: E if `resE == PC`; else M if `resM` is in {ALU, PC, MD}; else 0.
  - E selects: M if `resM` is in {ALU, PC, MD}; else W if `resW != NW`; else 0.
  - `fwd_rtM`: 1 if `ra2M != 0`, `ra2M == waW` and `resW != NW`.
- MD counter (4-bit, registered):
  - On a clock edge with `md_startE = 1`, it loads `DIV_CYC` if `md_divE`, else `MULT_CYC`.
  - Otherwise it decrements when nonzero.
  - `md_busy = (count != 0)`.
  - A start while busy reloads the counter; a reload takes priority over the decrement.
- Exception: `DEMWclr = exc_req & rst`, combinational. While `DEMWclr` is high, `stallF`, `stallD` and `clrE` are forced to 0 so the flush wins over a stall. The MD counter keeps counting through the flush; HI/LO completion is not cancelled.

## Timing
- Everything is combinational from the input tags, except the MD counter (one register).
- Reset (`rst = 0` at a posedge): counter cleared to 0, so `md_busy = 0` the next cycle.
- While `rst = 0`, all stall, clr and `DEMWclr` outputs are forced to 0 and all `fwd_*` are 0.
- A mult sampled at edge N: `md_busy` is high for cycles N+1 .. N+`MULT_CYC`, then low.
- An MD-using D instruction is stalled in the cycle the MD instruction is in E and for every busy cycle; it proceeds in the first cycle where `md_busy = 0`.
- Load-use with `tuse = 1`: exactly one stall cycle (load in E); the M→D... the value then forwards via the regfile/W path.
- Reset asserted mid-operation abandons the MD count immediately at that edge.

## Test plan
- Load-use:
  - Stimulus: `resE = DM`, `waE = 8`, `ra1D = 8`, `tuse_rsD = 1`.
  - Required: `stallF = stallD = clrE = 1`.
  - Next cycle, with `resM = DM`, `waM = 8`: no stall.
  - With `tuse_rsD = 2` in the first cycle: no stall.
- Register $0:
  - Stimulus: `waE = 0`, `resE = ALU`, `ra1D = 0`, `tuse = 0`.
  - Required: no stall, `fwd_rsD = 0`.
- Forward priority:
  - Stimulus: `ra1E = 5`, `waM = 5`, `resM = ALU`, `waW = 5`, `resW = DM`.
  - Required: `fwd_rsE = 1`.
  - With `resM = NW`: `fwd_rsE = 2`.
- Divide:
  - Stimulus: `md_startE = 1`, `md_divE = 1` at edge 0; `md_useD = 1` throughout.
  - Required: stall in cycle 0 and cycles 1-10; released in cycle 11; `md_busy` falls after exactly 10 cycles.
- Flush over stall:
  - Stimulus: load-use stall condition plus `exc_req = 1`.
  - Required: `DEMWclr = 1`, `stallF = stallD = clrE = 0`.
- Reset mid-multiply:
  - Stimulus: assert `rst = 0` two cycles after a mult start.
  - Required: `md_busy = 0` the next cycle; all outputs 0 while reset is held.
